// File: rtl/assoc_cache_ctrl_if.sv
// CPU-side and SRAM-side bus bundle for assoc_cache_ctrl.
// slave : the cache controller.
// master: whoever plays the CPU and the SRAM controller (e.g. a bench).
interface assoc_cache_ctrl_if #(
   parameter int unsigned ADDR_W = 32
);
   // CPU side
   logic [ADDR_W-1:0] address;
   logic [31:0]       wdata;
   logic              wr_en;
   logic              rd_en;
   logic [31:0]       rdata;
   logic              ready;
   // SRAM controller side
   logic [ADDR_W-1:0] sram_address;
   logic [31:0]       sram_wdata;
   logic              sram_wr_en;
   logic              sram_rd_en;
   logic [63:0]       sram_rdata;
   logic              sram_ready;
   // Statistics
   logic [15:0]       hit_count;
   logic [15:0]       miss_count;

   modport slave (
      input  address, wdata, wr_en, rd_en, sram_rdata, sram_ready,
      output rdata, ready, sram_address, sram_wdata, sram_wr_en, sram_rd_en,
      output hit_count, miss_count
   );

   modport master (
      output address, wdata, wr_en, rd_en, sram_rdata, sram_ready,
      input  rdata, ready, sram_address, sram_wdata, sram_wr_en, sram_rd_en,
      input  hit_count, miss_count
   );
endinterface

// File: rtl/assoc_cache_ctrl.sv
// 2-way set-associative, write-through / no-write-allocate cache controller
// with 64-bit lines and one LRU bit per set. Read hits complete combinationally;
// misses and writes go to the SRAM controller and complete on sram_ready.
// Optional feature macro: CACHE_STATS_EN adds saturating hit/miss counters.
module assoc_cache_ctrl #(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned SETS      = 64,
   parameter int unsigned BASE_ADDR = 1024
) (
   input logic               clk,
   input logic               rst,
   assoc_cache_ctrl_if.slave bus
);

   localparam int unsigned IdxW = $clog2(SETS);
   localparam int unsigned TagW = ADDR_W - 3 - IdxW;

   typedef enum logic [1:0] {StIdle, StRdMiss, StWrThru} state_e;

   state_e stateQ, stateD;

   logic [ADDR_W-1:0] offAddr;
   logic [ADDR_W-1:0] reqAddrQ;
   logic [31:0]       reqWdataQ;

   logic [SETS-1:0] valid0Q, valid1Q, lruQ;
   logic [TagW-1:0] tag0 [SETS];
   logic [TagW-1:0] tag1 [SETS];
   logic [63:0]     data0 [SETS];
   logic [63:0]     data1 [SETS];

   logic [IdxW-1:0] lookIdx;
   logic [TagW-1:0] lookTag;
   logic            lookWord;
   logic            hit0, hit1, hit, hitWay;
   logic [63:0]     hitLine;
   logic [31:0]     hitWord;

   logic        readLive, writeLive;
   logic        capture, fillEn, wrUpd, touch;
   logic        readyC;
   logic [31:0] rdataC;

   assign offAddr = bus.address - ADDR_W'(BASE_ADDR);

   // In IDLE the lookup uses the live CPU address; while busy it uses the captured one.
   assign lookIdx  = (stateQ == StIdle) ? offAddr[3 +: IdxW] : reqAddrQ[3 +: IdxW];
   assign lookTag  = (stateQ == StIdle) ? offAddr[ADDR_W-1 -: TagW] : reqAddrQ[ADDR_W-1 -: TagW];
   assign lookWord = (stateQ == StIdle) ? offAddr[2] : reqAddrQ[2];

   assign hit0    = valid0Q[lookIdx] && (tag0[lookIdx] == lookTag);
   assign hit1    = valid1Q[lookIdx] && (tag1[lookIdx] == lookTag);
   assign hit     = hit0 || hit1;
   assign hitWay  = hit1;
   assign hitLine = hit1 ? data1[lookIdx] : data0[lookIdx];
   assign hitWord = lookWord ? hitLine[63:32] : hitLine[31:0];

   // A busy request only completes if the CPU is still asking for the same thing;
   // otherwise it was abandoned and the SRAM result is dropped.
   assign readLive  = bus.rd_en && !bus.wr_en && (offAddr == reqAddrQ);
   assign writeLive = bus.wr_en && (offAddr == reqAddrQ);

   // Next-state and output decode.
   always_comb begin
      stateD  = stateQ;
      readyC  = 1'b0;
      rdataC  = '0;
      capture = 1'b0;
      fillEn  = 1'b0;
      wrUpd   = 1'b0;
      touch   = 1'b0;
      case (stateQ)
         StIdle: begin
            if (bus.wr_en) begin
               capture = 1'b1;
               stateD  = StWrThru;
            end else if (bus.rd_en) begin
               if (hit) begin
                  readyC = 1'b1;
                  rdataC = hitWord;
                  touch  = 1'b1;
               end else begin
                  capture = 1'b1;
                  stateD  = StRdMiss;
               end
            end else begin
               readyC = 1'b1;
            end
         end
         StRdMiss: begin
            if (bus.sram_ready) begin
               stateD = StIdle;
               if (readLive) begin
                  readyC = 1'b1;
                  rdataC = lookWord ? bus.sram_rdata[63:32] : bus.sram_rdata[31:0];
                  fillEn = 1'b1;
               end
            end
         end
         StWrThru: begin
            if (bus.sram_ready) begin
               stateD = StIdle;
               readyC = writeLive;
               // The SRAM write lands regardless, so a hit line is kept coherent.
               if (hit) begin
                  wrUpd = 1'b1;
                  touch = 1'b1;
               end
            end
         end
         default: stateD = StIdle;
      endcase
      if (!rst) begin
         readyC = 1'b1;
         rdataC = '0;
      end
   end

   // Control state, request capture, valid and LRU bits.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stateQ    <= StIdle;
         reqAddrQ  <= '0;
         reqWdataQ <= '0;
         valid0Q   <= '0;
         valid1Q   <= '0;
         lruQ      <= '0;
      end else begin
         stateQ <= stateD;
         if (capture) begin
            reqAddrQ  <= offAddr;
            reqWdataQ <= bus.wdata;
         end
         if (fillEn) begin
            if (lruQ[lookIdx]) valid1Q[lookIdx] <= 1'b1;
            else               valid0Q[lookIdx] <= 1'b1;
            lruQ[lookIdx] <= ~lruQ[lookIdx];
         end else if (touch) begin
            lruQ[lookIdx] <= ~hitWay;
         end
      end
   end

   // Tag and data arrays: written on a line fill or a write-through hit.
   always_ff @(posedge clk) begin
      if (fillEn) begin
         if (lruQ[lookIdx]) begin
            tag1[lookIdx]  <= lookTag;
            data1[lookIdx] <= bus.sram_rdata;
         end else begin
            tag0[lookIdx]  <= lookTag;
            data0[lookIdx] <= bus.sram_rdata;
         end
      end else if (wrUpd) begin
         if (hitWay) begin
            if (lookWord) data1[lookIdx][63:32] <= reqWdataQ;
            else          data1[lookIdx][31:0]  <= reqWdataQ;
         end else begin
            if (lookWord) data0[lookIdx][63:32] <= reqWdataQ;
            else          data0[lookIdx][31:0]  <= reqWdataQ;
         end
      end
   end

   assign bus.ready        = readyC;
   assign bus.rdata        = rdataC;
   assign bus.sram_rd_en   = (stateQ == StRdMiss);
   assign bus.sram_wr_en   = (stateQ == StWrThru);
   assign bus.sram_address = (stateQ == StRdMiss) ? {reqAddrQ[ADDR_W-1:3], 3'b000} : reqAddrQ;
   assign bus.sram_wdata   = reqWdataQ;

`ifdef CACHE_STATS_EN
   logic        hitInc, missInc;
   logic [15:0] hitCountQ, missCountQ;

   assign hitInc  = (stateQ == StIdle) && bus.rd_en && !bus.wr_en && hit && rst;
   assign missInc = fillEn;

   // Saturating statistics counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hitCountQ  <= '0;
         missCountQ <= '0;
      end else begin
         if (hitInc && (hitCountQ != 16'hFFFF))   hitCountQ  <= hitCountQ + 16'd1;
         if (missInc && (missCountQ != 16'hFFFF)) missCountQ <= missCountQ + 16'd1;
      end
   end

   assign bus.hit_count  = hitCountQ;
   assign bus.miss_count = missCountQ;
`else
   assign bus.hit_count  = '0;
   assign bus.miss_count = '0;
`endif

endmodule
